// File: rtl/tft_vid_rx.sv
// tft_vid_rx: receives TFT-style video (datavalid / h_sync / v_sync) and
// re-emits it as an Avalon-ST pixel stream with sop/eop frame markers.
// The receiver first measures the active timing over two frames. It locks only
// when two consecutive measurements agree, and then streams pixels through a
// small output FIFO.
// Optional feature: define TFT_VID_RX_STATS_EN to add the frame_cnt / err_cnt
// statistics outputs.
module tft_vid_rx #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 12
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  input  logic              overflow_clr,
  input  logic              src_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  output logic              src_sop,
  output logic              src_eop,
  output logic [CNT_W-1:0]  h_active,
  output logic [CNT_W-1:0]  v_active,
  output logic              locked,
`ifdef TFT_VID_RX_STATS_EN
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt,
`endif
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_SEEK,
    S_MEASURE,
    S_RUN,
    S_DROP
  } state_t;

  state_t state;

  // Input stage registers and edge history.
  logic [DATA_W-1:0] d_q;
  logic              dv_q, dv_q2;
  logic              vs_q, vs_q2;
  logic              frame_start;
  logic              line_end;

  // Timing counters and measurement state.
  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  line_cnt;
  logic [CNT_W-1:0]  meas_h;
  logic              meas_armed;
  logic              meas_ok;
  logic              frame_done;

  // Per-cycle pixel decisions.
  logic              pix_write;
  logic              pix_sop;
  logic              pix_eop;
  logic              ovf_evt;
  logic              run_err;

  // Output FIFO.
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [AW:0]       fill;
  logic              fifo_full;
  logic              rd_fire;
  logic              can_write;
  logic [EW-1:0]     head;

  // h_sync adds nothing beyond the datavalid edges that delimit lines.
  logic              unused_hsync;
  assign unused_hsync = vid_h_sync;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign frame_start = vs_q & ~vs_q2;
  assign line_end    = dv_q2 & ~dv_q;

  assign meas_ok = (meas_h == h_active) && (line_cnt == v_active) &&
                   (meas_h != '0) && (line_cnt != '0) &&
                   (meas_h != CNT_MAX) && (line_cnt != CNT_MAX);

  assign fill      = wr_ptr - rd_ptr;
  assign fifo_full = (fill == FULL_LVL);
  assign src_valid = (wr_ptr != rd_ptr);
  assign rd_fire   = src_valid & src_ready;
  // A full FIFO can still take a pixel when the sink frees a slot this cycle.
  assign can_write = ~fifo_full | rd_fire;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign src_data = src_valid ? head[DATA_W-1:0] : '0;
  assign src_eop  = src_valid & head[DATA_W];
  assign src_sop  = src_valid & head[DATA_W+1];

  // Register the raw video inputs once so the sync edges are detected on clean samples.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      d_q   <= '0;
      dv_q  <= 1'b0;
      dv_q2 <= 1'b0;
      vs_q  <= 1'b0;
      vs_q2 <= 1'b0;
    end else begin
      d_q   <= vid_data;
      dv_q  <= vid_datavalid;
      dv_q2 <= dv_q;
      vs_q  <= vid_v_sync;
      vs_q2 <= vs_q;
    end
  end

  // Decide for the staged pixel whether it is written, overflows, or breaks lock.
  always_comb begin
    pix_write = 1'b0;
    ovf_evt   = 1'b0;
    run_err   = 1'b0;
    pix_sop   = (pix_cnt == '0) && (line_cnt == '0);
    pix_eop   = (pix_cnt == h_active - CNT_ONE) && (line_cnt == v_active - CNT_ONE);
    if (state == S_RUN && !frame_done) begin
      if (frame_start) begin
        run_err = 1'b1;
      end else if (dv_q) begin
        if (pix_cnt >= h_active) begin
          run_err = 1'b1;
        end else if (!can_write) begin
          ovf_evt = 1'b1;
        end else begin
          pix_write = 1'b1;
        end
      end else if (line_end && pix_cnt != h_active) begin
        run_err = 1'b1;
      end
    end
  end

  // Main receiver FSM: seek, measure, stream, or drop; also owns lock and overflow.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_SEEK;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      meas_h     <= '0;
      meas_armed <= 1'b0;
      frame_done <= 1'b0;
      h_active   <= '0;
      v_active   <= '0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end

      case (state)
        S_SEEK: begin
          if (frame_start) begin
            state      <= S_MEASURE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            meas_h     <= '0;
            meas_armed <= 1'b1;
          end
        end

        S_MEASURE: begin
          if (frame_start) begin
            pix_cnt    <= '0;
            line_cnt   <= '0;
            meas_h     <= '0;
            meas_armed <= 1'b1;
            // A measurement that began mid-frame is incomplete and is not latched.
            if (meas_armed) begin
              h_active <= meas_h;
              v_active <= line_cnt;
              if (meas_ok) begin
                state      <= S_RUN;
                locked     <= 1'b1;
                frame_done <= 1'b0;
              end
            end
          end else begin
            if (dv_q) begin
              pix_cnt <= sat_inc(pix_cnt);
            end
            if (line_end) begin
              pix_cnt  <= '0;
              line_cnt <= sat_inc(line_cnt);
              if (line_cnt == '0) begin
                meas_h <= pix_cnt;
              end
            end
          end
        end

        S_RUN: begin
          if (run_err) begin
            state      <= S_MEASURE;
            locked     <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            meas_h     <= '0;
            meas_armed <= frame_start;
          end else if (frame_start) begin
            pix_cnt    <= '0;
            line_cnt   <= '0;
            frame_done <= 1'b0;
          end else if (ovf_evt) begin
            state <= S_DROP;
          end else if (pix_write) begin
            pix_cnt <= pix_cnt + CNT_ONE;
            if (pix_eop) begin
              frame_done <= 1'b1;
            end
          end else if (line_end && !frame_done) begin
            pix_cnt  <= '0;
            line_cnt <= sat_inc(line_cnt);
          end
        end

        S_DROP: begin
          if (frame_start) begin
            state      <= locked ? S_RUN : S_MEASURE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            meas_h     <= '0;
            meas_armed <= 1'b1;
            frame_done <= 1'b0;
          end
        end

        default: begin
          state <= S_SEEK;
        end
      endcase
    end
  end

  // FIFO storage carries {sop, eop, data} per entry and needs no reset.
  always_ff @(posedge clk_clk) begin
    if (pix_write) begin
      mem[wr_ptr[AW-1:0]] <= {pix_sop, pix_eop, d_q};
    end
  end

  // Write pointer advances on every accepted pixel and wraps through its extra bit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
    end else if (pix_write) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on every sink handshake.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_ptr <= '0;
    end else if (rd_fire) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

`ifdef TFT_VID_RX_STATS_EN
  // Count frames completed at the sink (wrapping) and lock/overflow errors (saturating).
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (rd_fire && src_eop) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if ((run_err || ovf_evt) && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tft_vid_rx.sv
// tb_tft_vid_rx: directed test of tft_vid_rx with 8x4 frames covering
// lock, relock after a truncated frame, overflow, backpressure and reset.
module tb_tft_vid_rx;

  logic        clk_clk;
  logic        reset_reset_n;
  logic [31:0] vid_data;
  logic        vid_datavalid;
  logic        vid_h_sync;
  logic        vid_v_sync;
  logic        overflow_clr;
  logic        src_ready;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_sop;
  logic        src_eop;
  logic [11:0] h_active;
  logic [11:0] v_active;
  logic        locked;
  logic        overflow;

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
  } rx_t;

  rx_t         rx_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        bp_en = 1'b0;
  logic        ready_lvl = 1'b1;
  logic        hold_pending = 1'b0;
  logic [33:0] hold_val;

  assign src_ready = bp_en ? !(((cyc % 5) == 1) || ((cyc % 7) == 3)) : ready_lvl;

  tft_vid_rx #(
    .DATA_W(32),
    .FIFO_DEPTH(16),
    .CNT_W(12)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .vid_data(vid_data),
    .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync),
    .vid_v_sync(vid_v_sync),
    .overflow_clr(overflow_clr),
    .src_ready(src_ready),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_sop(src_sop),
    .src_eop(src_eop),
    .h_active(h_active),
    .v_active(v_active),
    .locked(locked),
    .overflow(overflow)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record sink handshakes and check that a stalled beat holds steady.
  always @(negedge clk_clk) begin
    if (hold_pending && reset_reset_n) begin
      n_vec++;
      assert (src_valid === 1'b1 && {src_sop, src_eop, src_data} === hold_val) else begin
        n_bad++;
        $error("[TB] FAIL hold_stable: observed v=%0b 0x%0h expected v=1 0x%0h",
               src_valid, {src_sop, src_eop, src_data}, hold_val);
      end
    end
    if (reset_reset_n && src_valid && src_ready) begin
      rx_q.push_back('{src_data, src_sop, src_eop});
    end
    hold_pending = reset_reset_n && src_valid && !src_ready;
    hold_val     = {src_sop, src_eop, src_data};
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
    cyc++;
  endtask

  // One frame: v_sync pulse, blanking, then v lines of h pixels each.
  task automatic applyStimulus(input int h, input int v, input logic [31:0] base,
                               input int clr_idx, input bit lat_chk);
    int idx = 0;
    vid_v_sync = 1'b1;
    repeat (2) tick();
    vid_v_sync = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < v; y++) begin
      vid_h_sync = 1'b1;
      tick();
      vid_h_sync = 1'b0;
      tick();
      for (int x = 0; x < h; x++) begin
        vid_datavalid = 1'b1;
        vid_data      = base + 32'(idx);
        overflow_clr  = (idx == clr_idx);
        tick();
        if (lat_chk && idx == 0) checkOutput("latency_1cyc_valid", 32'(src_valid), 32'd0);
        if (lat_chk && idx == 1) begin
          checkOutput("latency_2cyc_valid", 32'(src_valid), 32'd1);
          checkOutput("latency_2cyc_data", src_data, base);
        end
        idx++;
      end
      vid_datavalid = 1'b0;
      overflow_clr  = 1'b0;
      repeat (4) tick();
    end
    repeat (3) tick();
  endtask

  task automatic waitDrain(input int n);
    for (int c = 0; c < 600 && rx_q.size() < n; c++) tick();
    repeat (4) tick();
  endtask

  task automatic checkFrame(input string tag, input int n, input logic [31:0] base, input bit has_eop);
    waitDrain(n);
    checkOutput({tag, "_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      checkOutput({tag, "_data"}, rx_q[i].d, base + 32'(i));
      checkOutput({tag, "_sop"}, 32'(rx_q[i].sop), 32'(i == 0));
      checkOutput({tag, "_eop"}, 32'(rx_q[i].eop), 32'(has_eop && i == n - 1));
    end
    rx_q.delete();
  endtask

  initial begin
    reset_reset_n = 1'b0;
    vid_data      = '0;
    vid_datavalid = 1'b0;
    vid_h_sync    = 1'b0;
    vid_v_sync    = 1'b0;
    overflow_clr  = 1'b0;
    repeat (3) tick();

    checkOutput("rst_src_valid", 32'(src_valid), 32'd0);
    checkOutput("rst_src_sop", 32'(src_sop), 32'd0);
    checkOutput("rst_src_eop", 32'(src_eop), 32'd0);
    checkOutput("rst_src_data", src_data, 32'd0);
    checkOutput("rst_h_active", 32'(h_active), 32'd0);
    checkOutput("rst_v_active", 32'(v_active), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);

    reset_reset_n = 1'b1;
    repeat (3) tick();

    // Three 8x4 frames: measure, confirm, then stream frame 3.
    $display("[TB] lock sequence");
    applyStimulus(8, 4, 32'h0100_0000, -1, 1'b0);
    applyStimulus(8, 4, 32'h0200_0000, -1, 1'b0);
    checkOutput("f2_locked", 32'(locked), 32'd0);
    checkOutput("f2_h_active", 32'(h_active), 32'd8);
    checkOutput("f2_v_active", 32'(v_active), 32'd4);
    checkOutput("f2_no_output", 32'(rx_q.size()), 32'd0);
    applyStimulus(8, 4, 32'h0300_0000, -1, 1'b1);
    checkOutput("f3_locked", 32'(locked), 32'd1);
    checkFrame("f3", 32, 32'h0300_0000, 1'b1);

    // Truncated fourth frame loses lock at the next frame start.
    $display("[TB] truncated frame");
    applyStimulus(8, 3, 32'h0400_0000, -1, 1'b0);
    applyStimulus(8, 4, 32'h0500_0000, -1, 1'b0);
    checkOutput("f5_locked", 32'(locked), 32'd0);
    checkFrame("f4", 24, 32'h0400_0000, 1'b0);
    applyStimulus(8, 4, 32'h0600_0000, -1, 1'b0);
    checkOutput("f6_relocked", 32'(locked), 32'd1);
    checkFrame("f6", 32, 32'h0600_0000, 1'b1);

    // Overflow with the sink stalled; clear requested in the same cycle.
    $display("[TB] overflow");
    ready_lvl = 1'b0;
    applyStimulus(8, 4, 32'h0700_0000, 17, 1'b0);
    checkOutput("f7_overflow", 32'(overflow), 32'd1);
    checkOutput("f7_locked", 32'(locked), 32'd1);
    checkOutput("f7_head_valid", 32'(src_valid), 32'd1);
    checkOutput("f7_head_data", src_data, 32'h0700_0000);
    ready_lvl = 1'b1;
    checkFrame("f7", 16, 32'h0700_0000, 1'b0);
    applyStimulus(8, 4, 32'h0800_0000, -1, 1'b0);
    checkFrame("f8", 32, 32'h0800_0000, 1'b1);
    checkOutput("f8_overflow_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checkOutput("overflow_cleared", 32'(overflow), 32'd0);

    // Patterned backpressure on the sink.
    $display("[TB] backpressure");
    bp_en = 1'b1;
    applyStimulus(8, 4, 32'h0900_0000, -1, 1'b0);
    waitDrain(32);
    bp_en = 1'b0;
    checkFrame("f9", 32, 32'h0900_0000, 1'b1);
    checkOutput("f9_overflow", 32'(overflow), 32'd0);

    // Reset mid-frame with buffered pixels and a raised overflow.
    $display("[TB] reset mid-frame");
    ready_lvl = 1'b0;
    applyStimulus(8, 3, 32'h0A00_0000, -1, 1'b0);
    checkOutput("f10_buffered", 32'(src_valid), 32'd1);
    checkOutput("f10_overflow", 32'(overflow), 32'd1);
    reset_reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_src_valid", 32'(src_valid), 32'd0);
    checkOutput("mid_rst_src_sop", 32'(src_sop), 32'd0);
    checkOutput("mid_rst_src_eop", 32'(src_eop), 32'd0);
    checkOutput("mid_rst_src_data", src_data, 32'd0);
    checkOutput("mid_rst_h_active", 32'(h_active), 32'd0);
    checkOutput("mid_rst_v_active", 32'(v_active), 32'd0);
    checkOutput("mid_rst_locked", 32'(locked), 32'd0);
    checkOutput("mid_rst_overflow", 32'(overflow), 32'd0);
    repeat (2) tick();
    reset_reset_n = 1'b1;
    ready_lvl = 1'b1;
    rx_q.delete();
    repeat (2) tick();
    applyStimulus(8, 4, 32'h0B00_0000, -1, 1'b0);
    applyStimulus(8, 4, 32'h0C00_0000, -1, 1'b0);
    checkOutput("f12_locked", 32'(locked), 32'd0);
    checkOutput("f12_no_output", 32'(rx_q.size()), 32'd0);
    applyStimulus(8, 4, 32'h0D00_0000, -1, 1'b0);
    checkOutput("f13_locked", 32'(locked), 32'd1);
    checkFrame("f13", 32, 32'h0D00_0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
